// File: rtl/bsg_mem_1rw_sync_mask_init_if.sv
// Request/response bundle for bsg_mem_1rw_sync_mask_init.
//
// Signal names follow the memory's point of view:
//   v_i, w_i, addr_i, data_i, w_mask_i : request from client (master) to memory (slave)
//   ready_o, data_o, v_o               : status and read response from memory to client
//
// Modports:
//   master : the client issuing requests
//   slave  : the memory block
interface bsg_mem_1rw_sync_mask_init_if #(
    parameter int unsigned width_p     = 64,
    parameter int unsigned els_p       = 512,
    parameter int unsigned mask_gran_p = 8
);
    localparam int unsigned addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int unsigned mask_width_lp = width_p / mask_gran_p;

    logic                     v_i;
    logic                     w_i;
    logic [addr_width_lp-1:0] addr_i;
    logic [width_p-1:0]       data_i;
    logic [mask_width_lp-1:0] w_mask_i;
    logic                     ready_o;
    logic [width_p-1:0]       data_o;
    logic                     v_o;

    modport master (
        output v_i, w_i, addr_i, data_i, w_mask_i,
        input  ready_o, data_o, v_o
    );

    modport slave (
        input  v_i, w_i, addr_i, data_i, w_mask_i,
        output ready_o, data_o, v_o
    );
endinterface

// File: rtl/bsg_mem_1rw_sync_mask_init.sv
// Single-port synchronous memory with per-lane write mask, held read register
// and a hardware zero-fill sweep after reset.
//
// After reset the block walks every address once, writing zero with the full
// mask. It then raises ready_o and serves one read or one write per cycle.
// Read data appears one cycle after acceptance with v_o high for that cycle.
// data_o keeps the last read value until the next accepted read.
//
// Ports:
//   clk_i   : clock
//   reset_i : synchronous active-high reset; restarts the sweep
//   bus     : request/response bundle (slave side), see bsg_mem_1rw_sync_mask_init_if
//
// The storage array is named mem so a hardened macro can replace it.
module bsg_mem_1rw_sync_mask_init #(
    parameter int unsigned width_p     = 64,
    parameter int unsigned els_p       = 512,
    parameter int unsigned mask_gran_p = 8
) (
    input logic                        clk_i,
    input logic                        reset_i,
    bsg_mem_1rw_sync_mask_init_if.slave bus
);
    localparam int unsigned addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int unsigned mask_width_lp = width_p / mask_gran_p;

    localparam logic [addr_width_lp-1:0] last_addr_lp = addr_width_lp'(els_p - 1);
    localparam logic [addr_width_lp:0]   els_lp       = (addr_width_lp + 1)'(els_p);

    typedef enum logic {
        StInit,
        StReady
    } state_e;

    state_e                   state_q, state_d;
    logic [addr_width_lp-1:0] cnt_q, cnt_d;
    logic                     v_q, v_d;
    logic [width_p-1:0]       data_q, data_d;

    logic                     ready;
    logic                     accept;

    logic                     mem_we;
    logic [addr_width_lp-1:0] mem_addr;
    logic [width_p-1:0]       mem_w_data;
    logic [mask_width_lp-1:0] mem_w_mask;

    logic [width_p-1:0]       mem [els_p];

    // ready is purely state-derived so there is no input-to-output path.
    assign ready  = (state_q == StReady);
    assign accept = bus.v_i & ready;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        v_d        = 1'b0;
        data_d     = data_q;
        mem_we     = 1'b0;
        mem_addr   = bus.addr_i;
        mem_w_data = bus.data_i;
        mem_w_mask = bus.w_mask_i;

        unique case (state_q)
            StInit: begin
                // Client requests are ignored; the sweep owns the array.
                mem_we     = 1'b1;
                mem_addr   = cnt_q;
                mem_w_data = '0;
                mem_w_mask = '1;
                cnt_d      = cnt_q + addr_width_lp'(1);
                if (cnt_q == last_addr_lp) begin
                    state_d = StReady;
                end
            end
            StReady: begin
                if (accept) begin
                    if (bus.w_i) begin
                        mem_we = 1'b1;
                    end else begin
                        v_d    = 1'b1;
                        data_d = mem[bus.addr_i];
                    end
                end
            end
        endcase

        // A request coinciding with reset has no effect on the array.
        if (reset_i) begin
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StInit;
            cnt_q   <= '0;
            v_q     <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            v_q     <= v_d;
            data_q  <= data_d;
        end
    end

    // Lane-masked write; unmasked lanes keep their previous contents.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int k = 0; k < int'(mask_width_lp); k++) begin
                if (mem_w_mask[k]) begin
                    mem[mem_addr][k*mask_gran_p +: mask_gran_p] <=
                        mem_w_data[k*mask_gran_p +: mask_gran_p];
                end
            end
        end
    end

    assign bus.ready_o = ready;
    assign bus.data_o  = data_q;
    assign bus.v_o     = v_q;

    // Out-of-range addresses are illegal; only checked in simulation.
    illegal_addr_a: assert property (
        @(posedge clk_i) disable iff (reset_i)
        accept |-> ({1'b0, bus.addr_i} < els_lp)
    );
endmodule

// File: tb/tb_bsg_mem_1rw_sync_mask_init.sv
// Directed bench for bsg_mem_1rw_sync_mask_init.
// Instance a: 64-bit words, 512 entries, byte mask.
// Instance b: 15-bit words, 12 entries, bit mask.
module tb_bsg_mem_1rw_sync_mask_init;
    logic clk;
    logic reset_i;

    int tests_run;
    int tests_failed;

    bsg_mem_1rw_sync_mask_init_if #(.width_p(64), .els_p(512), .mask_gran_p(8)) bus_a ();
    bsg_mem_1rw_sync_mask_init_if #(.width_p(15), .els_p(12), .mask_gran_p(1)) bus_b ();

    bsg_mem_1rw_sync_mask_init #(.width_p(64), .els_p(512), .mask_gran_p(8)) dut_a (
        .clk_i   (clk),
        .reset_i (reset_i),
        .bus     (bus_a)
    );

    bsg_mem_1rw_sync_mask_init #(.width_p(15), .els_p(12), .mask_gran_p(1)) dut_b (
        .clk_i   (clk),
        .reset_i (reset_i),
        .bus     (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past one rising edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_req(input logic w, input logic [8:0] addr, input logic [63:0] data,
                         input logic [7:0] mask);
        bus_a.v_i      = 1'b1;
        bus_a.w_i      = w;
        bus_a.addr_i   = addr;
        bus_a.data_i   = data;
        bus_a.w_mask_i = mask;
        step();
        bus_a.v_i = 1'b0;
        bus_a.w_i = 1'b0;
    endtask

    task automatic b_req(input logic w, input logic [3:0] addr, input logic [14:0] data,
                         input logic [14:0] mask);
        bus_b.v_i      = 1'b1;
        bus_b.w_i      = w;
        bus_b.addr_i   = addr;
        bus_b.data_i   = data;
        bus_b.w_mask_i = mask;
        step();
        bus_b.v_i = 1'b0;
        bus_b.w_i = 1'b0;
    endtask

    // Release reset and run the 512-cycle sweep of instance a, checking that
    // ready stays low in cycles 0..511, v_o stays low, and a write attempted
    // during init (address 2, 0xDEAD) is ignored.
    task automatic run_sweep(input string tag);
        int ready_early;
        int v_seen;
        ready_early = 0;
        v_seen      = 0;
        for (int c = 0; c < 512; c++) begin
            if (bus_a.ready_o !== 1'b0) ready_early++;
            if (bus_a.v_o !== 1'b0) v_seen++;
            bus_a.v_i      = (c >= 100 && c < 104);
            bus_a.w_i      = 1'b1;
            bus_a.addr_i   = 9'd2;
            bus_a.data_i   = 64'hDEAD;
            bus_a.w_mask_i = 8'hFF;
            step();
        end
        bus_a.v_i = 1'b0;
        bus_a.w_i = 1'b0;
        tests_run++;
        if (ready_early !== 0) begin
            tests_failed++;
            $display("FAIL %s ready_during_init: high in %0d cycles, required 0", tag,
                     ready_early);
        end
        tests_run++;
        if (v_seen !== 0) begin
            tests_failed++;
            $display("FAIL %s v_during_init: high in %0d cycles, required 0", tag, v_seen);
        end
        tests_run++;
        if (bus_a.ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s ready_cycle_512: got %b required 1", tag, bus_a.ready_o);
        end
        tests_run++;
        if (bus_b.ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s b_ready: got %b required 1", tag, bus_b.ready_o);
        end
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        step();
        step();
        tests_run++;
        if (bus_a.ready_o !== 1'b0 || bus_a.v_o !== 1'b0 || bus_a.data_o !== 64'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs_a: ready=%b v=%b data=%h required 0 0 0",
                     bus_a.ready_o, bus_a.v_o, bus_a.data_o);
        end
        tests_run++;
        if (bus_b.ready_o !== 1'b0 || bus_b.v_o !== 1'b0 || bus_b.data_o !== 15'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs_b: ready=%b v=%b data=%h required 0 0 0",
                     bus_b.ready_o, bus_b.v_o, bus_b.data_o);
        end
        reset_i = 1'b0;
        run_sweep("first_sweep");
    endtask

    task automatic test_init_reads();
        logic [8:0] addrs [4];
        addrs = '{9'd0, 9'd255, 9'd511, 9'd2};
        for (int i = 0; i < 4; i++) begin
            a_req(1'b0, addrs[i], 64'h0, 8'h0);
            tests_run++;
            if (bus_a.v_o !== 1'b1 || bus_a.data_o !== 64'h0) begin
                tests_failed++;
                $display("FAIL init_read_%0d: v=%b data=%h required v=1 data=0", addrs[i],
                         bus_a.v_o, bus_a.data_o);
            end
        end
        step();
        tests_run++;
        if (bus_a.v_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL v_one_cycle: got %b required 0", bus_a.v_o);
        end
        b_req(1'b0, 4'd11, 15'h0, 15'h0);
        tests_run++;
        if (bus_b.v_o !== 1'b1 || bus_b.data_o !== 15'h0) begin
            tests_failed++;
            $display("FAIL b_init_read_11: v=%b data=%h required v=1 data=0",
                     bus_b.v_o, bus_b.data_o);
        end
    endtask

    task automatic test_byte_mask();
        a_req(1'b1, 9'd7, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        a_req(1'b1, 9'd7, 64'h1122_3344_5566_7788, 8'h05);
        a_req(1'b0, 9'd7, 64'h0, 8'h0);
        tests_run++;
        if (bus_a.v_o !== 1'b1 || bus_a.data_o !== 64'hFFFF_FFFF_FF66_FF88) begin
            tests_failed++;
            $display("FAIL byte_mask: v=%b data=%h required v=1 data=ffffffffff66ff88",
                     bus_a.v_o, bus_a.data_o);
        end
        // All-zero mask is a no-op.
        a_req(1'b1, 9'd7, 64'h0, 8'h00);
        a_req(1'b0, 9'd7, 64'h0, 8'h0);
        tests_run++;
        if (bus_a.data_o !== 64'hFFFF_FFFF_FF66_FF88) begin
            tests_failed++;
            $display("FAIL zero_mask: data=%h required ffffffffff66ff88", bus_a.data_o);
        end
    endtask

    task automatic test_bit_mask();
        b_req(1'b1, 4'd3, 15'h7FFF, 15'h7FFF);
        b_req(1'b1, 4'd3, 15'h0000, 15'h00F0);
        b_req(1'b0, 4'd3, 15'h0, 15'h0);
        tests_run++;
        if (bus_b.v_o !== 1'b1 || bus_b.data_o !== 15'h7F0F) begin
            tests_failed++;
            $display("FAIL bit_mask: v=%b data=%h required v=1 data=7f0f",
                     bus_b.v_o, bus_b.data_o);
        end
    endtask

    task automatic test_hold();
        a_req(1'b1, 9'd5, 64'hA5, 8'hFF);
        a_req(1'b0, 9'd5, 64'h0, 8'h0);
        tests_run++;
        if (bus_a.v_o !== 1'b1 || bus_a.data_o !== 64'hA5) begin
            tests_failed++;
            $display("FAIL hold_read: v=%b data=%h required v=1 data=a5",
                     bus_a.v_o, bus_a.data_o);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            tests_run++;
            if (bus_a.v_o !== 1'b0 || bus_a.data_o !== 64'hA5) begin
                tests_failed++;
                $display("FAIL hold_idle_%0d: v=%b data=%h required v=0 data=a5", i,
                         bus_a.v_o, bus_a.data_o);
            end
        end
        a_req(1'b1, 9'd5, 64'h5A, 8'hFF);
        tests_run++;
        if (bus_a.v_o !== 1'b0 || bus_a.data_o !== 64'hA5) begin
            tests_failed++;
            $display("FAIL hold_write: v=%b data=%h required v=0 data=a5",
                     bus_a.v_o, bus_a.data_o);
        end
        // Read right after the write sees the new value.
        a_req(1'b0, 9'd5, 64'h0, 8'h0);
        tests_run++;
        if (bus_a.v_o !== 1'b1 || bus_a.data_o !== 64'h5A) begin
            tests_failed++;
            $display("FAIL write_then_read: v=%b data=%h required v=1 data=5a",
                     bus_a.v_o, bus_a.data_o);
        end
    endtask

    task automatic test_back_to_back();
        a_req(1'b1, 9'd10, 64'h10, 8'hFF);
        a_req(1'b1, 9'd11, 64'h11, 8'hFF);
        a_req(1'b0, 9'd10, 64'h0, 8'h0);
        tests_run++;
        if (bus_a.v_o !== 1'b1 || bus_a.data_o !== 64'h10) begin
            tests_failed++;
            $display("FAIL b2b_first: v=%b data=%h required v=1 data=10",
                     bus_a.v_o, bus_a.data_o);
        end
        a_req(1'b0, 9'd11, 64'h0, 8'h0);
        tests_run++;
        if (bus_a.v_o !== 1'b1 || bus_a.data_o !== 64'h11) begin
            tests_failed++;
            $display("FAIL b2b_second: v=%b data=%h required v=1 data=11",
                     bus_a.v_o, bus_a.data_o);
        end
        step();
        tests_run++;
        if (bus_a.v_o !== 1'b0 || bus_a.data_o !== 64'h11) begin
            tests_failed++;
            $display("FAIL b2b_after: v=%b data=%h required v=0 data=11",
                     bus_a.v_o, bus_a.data_o);
        end
    endtask

    task automatic test_reset_midstream();
        a_req(1'b1, 9'd9, 64'h1234, 8'hFF);
        a_req(1'b0, 9'd9, 64'h0, 8'h0);
        tests_run++;
        if (bus_a.data_o !== 64'h1234) begin
            tests_failed++;
            $display("FAIL pre_reset_read: data=%h required 1234", bus_a.data_o);
        end
        // Reset rises together with an accepted read on both instances.
        reset_i        = 1'b1;
        bus_a.v_i      = 1'b1;
        bus_a.w_i      = 1'b0;
        bus_a.addr_i   = 9'd9;
        bus_b.v_i      = 1'b1;
        bus_b.w_i      = 1'b0;
        bus_b.addr_i   = 4'd3;
        step();
        tests_run++;
        if (bus_a.ready_o !== 1'b0 || bus_a.v_o !== 1'b0 || bus_a.data_o !== 64'h0) begin
            tests_failed++;
            $display("FAIL midreset_a: ready=%b v=%b data=%h required 0 0 0",
                     bus_a.ready_o, bus_a.v_o, bus_a.data_o);
        end
        tests_run++;
        if (bus_b.ready_o !== 1'b0 || bus_b.v_o !== 1'b0 || bus_b.data_o !== 15'h0) begin
            tests_failed++;
            $display("FAIL midreset_b: ready=%b v=%b data=%h required 0 0 0",
                     bus_b.ready_o, bus_b.v_o, bus_b.data_o);
        end
        reset_i   = 1'b0;
        bus_a.v_i = 1'b0;
        bus_b.v_i = 1'b0;
        run_sweep("second_sweep");
        a_req(1'b0, 9'd9, 64'h0, 8'h0);
        tests_run++;
        if (bus_a.v_o !== 1'b1 || bus_a.data_o !== 64'h0) begin
            tests_failed++;
            $display("FAIL post_reset_read_9: v=%b data=%h required v=1 data=0",
                     bus_a.v_o, bus_a.data_o);
        end
        b_req(1'b0, 4'd3, 15'h0, 15'h0);
        tests_run++;
        if (bus_b.v_o !== 1'b1 || bus_b.data_o !== 15'h0) begin
            tests_failed++;
            $display("FAIL post_reset_read_b3: v=%b data=%h required v=1 data=0",
                     bus_b.v_o, bus_b.data_o);
        end
    endtask

    initial begin
        tests_run      = 0;
        tests_failed   = 0;
        reset_i        = 1'b1;
        bus_a.v_i      = 1'b0;
        bus_a.w_i      = 1'b0;
        bus_a.addr_i   = '0;
        bus_a.data_i   = '0;
        bus_a.w_mask_i = '0;
        bus_b.v_i      = 1'b0;
        bus_b.w_i      = 1'b0;
        bus_b.addr_i   = '0;
        bus_b.data_i   = '0;
        bus_b.w_mask_i = '0;

        test_reset();
        test_init_reads();
        test_byte_mask();
        test_bit_mask();
        test_hold();
        test_back_to_back();
        test_reset_midstream();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
